hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the fixed E/M/W hazard logic. It holds a shift-register scoreboard of in-flight writers across `NSTAGE` post-decode stages, with per-entry Tnew countdown. From that scoreboard it produces the decode stall and the D-stage and E-stage forwarding selects. It also owns the HI/LO multiply/divide busy counter with configurable latencies, and the eret-after-mtc0(EPC) interlock. It sits beside the decoder and drives the pipeline enable, bubble-insert and bypass-mux controls.

## Interface
Parameters:
- `NSTAGE`, 3: post-decode stages tracked; index 0 = E, 1 = M, 2 = W. Legal range 2..6.
- `MULT_LAT`, 5: busy cycles loaded for mult/multu.
- `DIV_LAT`, 10: busy cycles loaded for div/divu.
- `EPC_STAGE`, 1: stage index at whose end mtc0 writes EPC.
- `SW`: localparam = $clog2(NSTAGE+1), width of forward selects.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `d_valid`, in, 1: decode slot holds a real instruction.
- `d_rs`, `d_rt`, in, 5 each: decode source registers.
- `d_tuse_rs`, `d_tuse_rt`, in, 2 each: Tuse; 3 = operand unused.
- `d_wra`, in, 5: decode destination; 0 = no GPR write.
- `d_tnew`, in, 2: Tnew on entering E.
- `d_md`, in, 1: instruction accesses HI/LO or the MD unit.
- `d_md_start`, in, 1: mult/multu/div/divu.
- `d_md_div`, in, 1: qualifies `d_md_start` as a divide.
- `d_mtc0_epc`, in, 1: mtc0 targeting EPC (reg 14).
- `d_eret`, in, 1: eret.
- `e_rs`, `e_rt`, in, 5 each: sources of the instruction in E.
- `flush`, in, 1: kill all in-flight entries.
- `stall`, out, 1: hold PC/IF/ID and insert a bubble into E.
- `fwd_rs_d`, `fwd_rt_d`, out, SW each: 0 = register file; k+1 = result of stage k.
- `fwd_rs_e`, `fwd_rt_e`, out, SW each: 0 = pipeline register; k+1 = stage k, where k ≥ 1.
- `md_busy`, out, 1: MD counter nonzero.

## Operation
- **Scoreboard entry** k holds {`v`, `wra[4:0]`, `tnew[1:0]`, `epc`}.
- **Advance, every cycle:** entry k ← entry k-1 with `tnew` decremented, saturating at 0.
- **Entry 0 load:**
  - Bubble (v=0) when `stall` or `!d_valid`.
  - Otherwise loads {1, `d_wra`, `d_tnew`, `d_mtc0_epc`}.
- **Flush:** all entries become invalid next cycle. Flush overrides stall and load.
- **Match(k, r):** `v_k && wra_k != 0 && wra_k == r`.
- **GPR stall:** asserted for any k with Match(k, `d_rs`) and `tnew_k > d_tuse_rs`; same rule for rt. Tuse 3 never stalls.
- **MD counter:**
  - Issue = `d_valid && d_md_start && !stall && !flush`.
  - On issue, loads `DIV_LAT` if `d_md_div`, else `MULT_LAT`.
  - Otherwise decrements while nonzero.
  - Flush does not cancel a running count.
- **MD stall:** `d_valid && d_md && md_busy`.
- **eret stall:** `d_valid && d_eret` and any `v_k && epc_k` with k ≤ `EPC_STAGE`.
- **Stall output:** `stall` = OR of GPR, MD and eret stalls, all gated by `!reset`.
- **D forward:**
  - Take the youngest (lowest k) entry with Match(k, `d_rs`).
  - If its `tnew` == 0, `fwd_rs_d` = k+1; otherwise 0.
  - An older ready match is never selected past a younger pending one.
  - Same rule for rt.
- **E forward:** same youngest-match rule over k = 1..NSTAGE-1 against `e_rs`/`e_rt`. The result is 0 if no match or the youngest match is not ready.

## Timing
- **Reset:** all entries invalid and MD counter 0, so `stall`=0, `md_busy`=0 and all `fwd_*`=0 in the cycle after reset.
- **Outputs:** all combinational from current state and inputs.
- **State update:** entries and counter update on the clk rising edge only.
- **Load-use** (Tnew 2, Tuse 1): exactly 1 stall cycle. Tnew 2 with Tuse 0: 2 stall cycles.
- **MD:** `md_busy` rises the cycle after issue and stays high for exactly LAT cycles.
- **Simultaneous flush + stall:** entries cleared and counter not loaded; `stall` still reported combinationally that cycle.
- **Reset mid-MD operation:** counter forced to 0.

## Test plan
- **Load-use:** lw $8 (tnew 2) then addu rs=$8 (tuse 1).
  - Required: `stall`=1 for one cycle.
  - Next cycle: `fwd_rs_d`=0.
  - When addu is in E: `fwd_rs_e`=3 (W).
- **Branch after ALU:** addu $9 (tnew 1) then beq rs=$9 (tuse 0).
  - Required: 1 stall cycle, then `fwd_rs_d`=2.
- **Register $0:** lw $0 then addu rs=$0.
  - Required: `stall`=0 and `fwd_rs_d`=0 throughout.
- **Youngest match:** addu $5 (tnew 1) followed immediately by lw $5 (tnew 2), then consumer rt=$5 with tuse 2.
  - Required: `stall`=0.
  - `fwd_rt_d`=0 while lw is pending, never 3.
- **MD interlock:** div issued, then mfhi.
  - Required: `md_busy` high 10 cycles and mfhi stalled 10 cycles.
  - With `DIV_LAT`=4: 4 cycles.
- **eret and flush:**
  - mtc0 EPC followed by eret: 2 stall cycles (`EPC_STAGE`=1).
  - `flush` asserted with a pending lw: all outputs 0 the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Shift-register scoreboard of in-flight GPR writers that
//               produces the decode stall and the D/E-stage bypass selects,
//               plus the HI/LO busy counter and the eret-after-mtc0 interlock.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter  int NSTAGE    = 3,
    parameter  int MULT_LAT  = 5,
    parameter  int DIV_LAT   = 10,
    parameter  int EPC_STAGE = 1,
    localparam int SW        = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [1:0]    d_tuse_rs,
    input  logic [1:0]    d_tuse_rt,
    input  logic [4:0]    d_wra,
    input  logic [1:0]    d_tnew,
    input  logic          d_md,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_mtc0_epc,
    input  logic          d_eret,
    input  logic [4:0]    e_rs,
    input  logic [4:0]    e_rt,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_d,
    output logic [SW-1:0] fwd_rt_d,
    output logic [SW-1:0] fwd_rs_e,
    output logic [SW-1:0] fwd_rt_e,
    output logic          md_busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [NSTAGE-1:0]      v_q, v_d;
    logic [NSTAGE-1:0]      epc_q, epc_d;
    logic [NSTAGE-1:0][4:0] wra_q, wra_d;
    logic [NSTAGE-1:0][1:0] tnew_q, tnew_d;
    logic [CW-1:0]          md_cnt_q, md_cnt_d;

    logic w_stall_gpr;
    logic w_epc_pending;
    logic w_stall_md;
    logic w_stall_eret;
    logic w_load;
    logic w_md_issue;

    // Stall sources; a Tuse of 3 marks an unused operand and never interlocks.
    always_comb begin
        w_stall_gpr   = 1'b0;
        w_epc_pending = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (v_q[k] && wra_q[k] != 5'd0 && wra_q[k] == d_rs &&
                d_tuse_rs != 2'd3 && tnew_q[k] > d_tuse_rs)
                w_stall_gpr = 1'b1;
            if (v_q[k] && wra_q[k] != 5'd0 && wra_q[k] == d_rt &&
                d_tuse_rt != 2'd3 && tnew_q[k] > d_tuse_rt)
                w_stall_gpr = 1'b1;
            if (k <= EPC_STAGE && v_q[k] && epc_q[k])
                w_epc_pending = 1'b1;
        end
        w_stall_md   = d_valid && d_md && (md_cnt_q != '0);
        w_stall_eret = d_valid && d_eret && w_epc_pending;
        stall        = !reset && (w_stall_gpr || w_stall_md || w_stall_eret);
        md_busy      = (md_cnt_q != '0);
    end

    // Walk oldest to youngest so the youngest match wins, ready or not.
    always_comb begin
        fwd_rs_d = '0;
        fwd_rt_d = '0;
        fwd_rs_e = '0;
        fwd_rt_e = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (v_q[k] && wra_q[k] != 5'd0 && wra_q[k] == d_rs)
                fwd_rs_d = (tnew_q[k] == 2'd0) ? SW'(k + 1) : '0;
            if (v_q[k] && wra_q[k] != 5'd0 && wra_q[k] == d_rt)
                fwd_rt_d = (tnew_q[k] == 2'd0) ? SW'(k + 1) : '0;
            if (k >= 1 && v_q[k] && wra_q[k] != 5'd0 && wra_q[k] == e_rs)
                fwd_rs_e = (tnew_q[k] == 2'd0) ? SW'(k + 1) : '0;
            if (k >= 1 && v_q[k] && wra_q[k] != 5'd0 && wra_q[k] == e_rt)
                fwd_rt_e = (tnew_q[k] == 2'd0) ? SW'(k + 1) : '0;
        end
    end

    always_comb begin
        w_load    = d_valid && !stall;
        v_d[0]    = w_load;
        wra_d[0]  = w_load ? d_wra  : 5'd0;
        tnew_d[0] = w_load ? d_tnew : 2'd0;
        epc_d[0]  = w_load && d_mtc0_epc;
        for (int k = 1; k < NSTAGE; k++) begin
            v_d[k]    = v_q[k-1];
            wra_d[k]  = wra_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == 2'd0) ? 2'd0 : tnew_q[k-1] - 2'd1;
            epc_d[k]  = epc_q[k-1];
        end
        if (flush)
            v_d = '0;

        // A running multiply/divide keeps counting across a flush.
        w_md_issue = d_valid && d_md_start && !stall && !flush;
        if (w_md_issue)
            md_cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CW'(1);
        else
            md_cnt_d = md_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q      <= '0;
            epc_q    <= '0;
            wra_q    <= '0;
            tnew_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            v_q      <= v_d;
            epc_q    <= epc_d;
            wra_q    <= wra_d;
            tnew_q   <= tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed, table-driven bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MDUSE = 3'd3;
    localparam logic [2:0] OP_MTC0  = 3'd4;
    localparam logic [2:0] OP_ERET  = 3'd5;

    logic       clk = 1'b0;
    logic       reset, d_valid, d_md, d_md_start, d_md_div, d_mtc0_epc, d_eret, flush;
    logic [4:0] d_rs, d_rt, d_wra, e_rs, e_rt;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       stall, md_busy, stall4, md_busy4;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [1:0] f4_rs_d, f4_rt_d, f4_rs_e, f4_rt_e;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wra(d_wra), .d_tnew(d_tnew),
        .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_mtc0_epc(d_mtc0_epc), .d_eret(d_eret), .e_rs(e_rs), .e_rt(e_rt),
        .flush(flush), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
    );

    hazard_scoreboard #(.DIV_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wra(d_wra), .d_tnew(d_tnew),
        .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_mtc0_epc(d_mtc0_epc), .d_eret(d_eret), .e_rs(e_rs), .e_rt(e_rt),
        .flush(flush), .stall(stall4), .fwd_rs_d(f4_rs_d), .fwd_rt_d(f4_rt_d),
        .fwd_rs_e(f4_rs_e), .fwd_rt_e(f4_rt_e), .md_busy(md_busy4)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] op;
        logic [4:0] rs, rt;
        logic [1:0] tur, tut;
        logic [4:0] wra;
        logic [1:0] tnew;
        logic [4:0] ers, ert;
        logic       fl;
        logic       st;
        logic [1:0] frd, frt, fre, fte;
        logic       busy;
    } vec_t;

    function automatic vec_t V(input logic rst, input logic v, input logic [2:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tur, input logic [1:0] tut,
                               input logic [4:0] wra, input logic [1:0] tnew,
                               input logic [4:0] ers, input logic [4:0] ert,
                               input logic fl, input logic st,
                               input logic [1:0] frd, input logic [1:0] frt,
                               input logic [1:0] fre, input logic [1:0] fte,
                               input logic busy);
        vec_t r;
        r.rst = rst;  r.v = v;     r.op = op;   r.rs = rs;   r.rt = rt;
        r.tur = tur;  r.tut = tut; r.wra = wra; r.tnew = tnew;
        r.ers = ers;  r.ert = ert; r.fl = fl;   r.st = st;
        r.frd = frd;  r.frt = frt; r.fre = fre; r.fte = fte; r.busy = busy;
        return r;
    endfunction

    function automatic vec_t IDLE();
        return V(0,0,OP_NONE,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0);
    endfunction

    task automatic apply(input vec_t x);
        reset      = x.rst;
        d_valid    = x.v;
        d_rs       = x.rs;
        d_rt       = x.rt;
        d_tuse_rs  = x.tur;
        d_tuse_rt  = x.tut;
        d_wra      = x.wra;
        d_tnew     = x.tnew;
        d_md       = (x.op == OP_MULT) || (x.op == OP_DIV) || (x.op == OP_MDUSE);
        d_md_start = (x.op == OP_MULT) || (x.op == OP_DIV);
        d_md_div   = (x.op == OP_DIV);
        d_mtc0_epc = (x.op == OP_MTC0);
        d_eret     = (x.op == OP_ERET);
        e_rs       = x.ers;
        e_rt       = x.ert;
        flush      = x.fl;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t x);
        @(negedge clk);
        apply(x);
        #1;
    endtask

    vec_t tbl[$];
    int   c_st, c_b, c_st4, c_b4;

    initial begin
        // rst v  op        rs rt tur tut wra tnew ers ert fl | st frd frt fre fte busy
        tbl.push_back(V(1,0,OP_NONE ,0,0,3,3,0 ,0,0,0,0, 0,0,0,0,0,0)); // in reset
        tbl.push_back(IDLE());                                          // first cycle out
        tbl.push_back(V(0,1,OP_NONE ,0,0,3,3,8 ,2,0,0,0, 0,0,0,0,0,0)); // lw $8
        tbl.push_back(V(0,1,OP_NONE ,8,0,1,3,10,1,0,0,0, 1,0,0,0,0,0)); // addu rs=$8
        tbl.push_back(V(0,1,OP_NONE ,8,0,1,3,10,1,0,0,0, 0,0,0,0,0,0)); // addu released
        tbl.push_back(V(0,0,OP_NONE ,0,0,3,3,0 ,0,8,0,0, 0,0,0,3,0,0)); // addu in E, W fwd
        tbl.push_back(IDLE());
        tbl.push_back(IDLE());
        tbl.push_back(V(0,1,OP_NONE ,0,0,3,3,9 ,1,0,0,0, 0,0,0,0,0,0)); // addu $9
        tbl.push_back(V(0,1,OP_NONE ,9,0,0,3,0 ,0,0,0,0, 1,0,0,0,0,0)); // beq rs=$9
        tbl.push_back(V(0,1,OP_NONE ,9,0,0,3,0 ,0,0,0,0, 0,2,0,0,0,0)); // beq from M
        tbl.push_back(IDLE());
        tbl.push_back(IDLE());
        tbl.push_back(V(0,1,OP_NONE ,0,0,3,3,0 ,2,0,0,0, 0,0,0,0,0,0)); // lw $0
        tbl.push_back(V(0,1,OP_NONE ,0,0,1,3,10,1,0,0,0, 0,0,0,0,0,0)); // addu rs=$0
        tbl.push_back(IDLE());
        tbl.push_back(IDLE());
        tbl.push_back(IDLE());
        tbl.push_back(V(0,1,OP_NONE ,0,0,3,3,5 ,1,0,0,0, 0,0,0,0,0,0)); // addu $5
        tbl.push_back(V(0,1,OP_NONE ,0,0,3,3,5 ,2,0,0,0, 0,0,0,0,0,0)); // lw $5
        tbl.push_back(V(0,1,OP_NONE ,0,5,3,2,11,1,0,0,0, 0,0,0,0,0,0)); // rt=$5 tuse 2
        tbl.push_back(V(0,0,OP_NONE ,0,5,3,3,0 ,0,0,5,0, 0,0,0,0,0,0)); // lw pending in M
        tbl.push_back(V(0,0,OP_NONE ,0,5,3,3,0 ,0,0,0,0, 0,0,3,0,0,0)); // lw ready in W
        tbl.push_back(IDLE());
        tbl.push_back(V(0,1,OP_MTC0 ,0,0,3,3,0 ,0,0,0,0, 0,0,0,0,0,0)); // mtc0 EPC
        tbl.push_back(V(0,1,OP_ERET ,0,0,3,3,0 ,0,0,0,0, 1,0,0,0,0,0)); // eret
        tbl.push_back(V(0,1,OP_ERET ,0,0,3,3,0 ,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,1,OP_ERET ,0,0,3,3,0 ,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(IDLE());
        tbl.push_back(V(0,1,OP_MULT ,0,0,3,3,0 ,0,0,0,0, 0,0,0,0,0,0)); // mult
        for (int i = 0; i < 5; i++)
            tbl.push_back(V(0,1,OP_MDUSE,0,0,3,3,0,0,0,0,0, 1,0,0,0,0,1)); // mfhi held
        tbl.push_back(V(0,1,OP_MDUSE,0,0,3,3,0 ,0,0,0,0, 0,0,0,0,0,0));

        apply(V(1,0,OP_NONE,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0));
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            step(tbl[i]);
            chk($sformatf("row%0d.stall",    i), {7'd0, stall},    {7'd0, tbl[i].st});
            chk($sformatf("row%0d.fwd_rs_d", i), {6'd0, fwd_rs_d}, {6'd0, tbl[i].frd});
            chk($sformatf("row%0d.fwd_rt_d", i), {6'd0, fwd_rt_d}, {6'd0, tbl[i].frt});
            chk($sformatf("row%0d.fwd_rs_e", i), {6'd0, fwd_rs_e}, {6'd0, tbl[i].fre});
            chk($sformatf("row%0d.fwd_rt_e", i), {6'd0, fwd_rt_e}, {6'd0, tbl[i].fte});
            chk($sformatf("row%0d.md_busy",  i), {7'd0, md_busy},  {7'd0, tbl[i].busy});
        end

        // div followed by a held mfhi: count busy and stalled cycles
        step(V(0,1,OP_DIV,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0));
        chk("div_issue.stall", {7'd0, stall}, 8'd0);
        c_st = 0; c_b = 0; c_st4 = 0; c_b4 = 0;
        for (int i = 0; i < 14; i++) begin
            step(V(0,1,OP_MDUSE,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0));
            c_st  += int'(stall);
            c_b   += int'(md_busy);
            c_st4 += int'(stall4);
            c_b4  += int'(md_busy4);
        end
        chk("div10.busy_cycles",  8'(c_b),   8'd10);
        chk("div10.stall_cycles", 8'(c_st),  8'd10);
        chk("div4.busy_cycles",   8'(c_b4),  8'd4);
        chk("div4.stall_cycles",  8'(c_st4), 8'd4);

        // reset in the middle of a divide
        step(V(0,1,OP_DIV,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0));
        step(IDLE());
        chk("mdreset.busy_before", {7'd0, md_busy}, 8'd1);
        step(V(1,1,OP_MDUSE,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0));
        chk("mdreset.stall_gated", {7'd0, stall}, 8'd0);
        step(IDLE());
        chk("mdreset.busy_after", {7'd0, md_busy}, 8'd0);

        // flush with a pending lw and a would-be load in the same cycle
        step(V(0,1,OP_NONE,0,0,3,3,8,2,0,0,0, 0,0,0,0,0,0));
        step(V(0,1,OP_NONE,8,0,1,3,8,2,0,0,1, 0,0,0,0,0,0));
        chk("flush.stall_same_cycle", {7'd0, stall}, 8'd1);
        step(V(0,1,OP_NONE,8,8,1,1,0,0,8,8,0, 0,0,0,0,0,0));
        chk("flush.stall",    {7'd0, stall},    8'd0);
        chk("flush.fwd_rs_d", {6'd0, fwd_rs_d}, 8'd0);
        chk("flush.fwd_rt_d", {6'd0, fwd_rt_d}, 8'd0);
        chk("flush.fwd_rs_e", {6'd0, fwd_rs_e}, 8'd0);
        chk("flush.fwd_rt_e", {6'd0, fwd_rt_e}, 8'd0);
        chk("flush.md_busy",  {7'd0, md_busy},  8'd0);

        // a flush does not cancel a running multiply
        step(V(0,1,OP_MULT,0,0,3,3,0,0,0,0,0, 0,0,0,0,0,0));
        step(V(0,0,OP_NONE,0,0,3,3,0,0,0,0,1, 0,0,0,0,0,0));
        chk("mdflush.busy1", {7'd0, md_busy}, 8'd1);
        step(IDLE());
        chk("mdflush.busy2", {7'd0, md_busy}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
